// File: rtl/div_arbiter.sv
// Round-robin front end for one shared signed Q-format divider: per-requester
// operand slots, rotating grant, level start/done handshake, local div-by-zero and timeout.
module div_arbiter_slot #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] num_in,
  input  logic [W-1:0] den_in,
  output logic         pending,
  output logic [W-1:0] num,
  output logic [W-1:0] den
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      num     <= '0;
      den     <= '0;
    end else if (load) begin
      pending <= 1'b1;
      num     <= num_in;
      den     <= den_in;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end
endmodule

module div_arbiter #(
  parameter int NREQ    = 3,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*W-1:0]       req_num,
  input  logic [NREQ*W-1:0]       req_den,
  output logic                    resp_valid,
  output logic [$clog2(NREQ)-1:0] resp_id,
  output logic [W-1:0]            resp_result,
  output logic                    resp_err,
  output logic                    busy,
  output logic                    div_start,
  output logic [W-1:0]            div_num,
  output logic [W-1:0]            div_den,
  input  logic                    div_done,
  input  logic [W-1:0]            div_result
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                   state, state_n;
  logic [IW-1:0]            rr_ptr, rr_n, win;
  logic [CW-1:0]            cnt, cnt_n;
  logic                     found;
  logic [NREQ-1:0]          pending, load, clear;
  logic [NREQ-1:0][W-1:0]   slot_num, slot_den;
  logic                     start_n, rv_n, err_n;
  logic [W-1:0]             num_n, den_n, res_n;
  logic [IW-1:0]            rid_n;

  // Ready is low while a slot is pending, so load and clear never hit the same slot.
  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign load[i] = req_valid[i] & ~pending[i];
    div_arbiter_slot #(.W(W)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .load    (load[i]),
      .clear   (clear[i]),
      .num_in  (req_num[i*W +: W]),
      .den_in  (req_den[i*W +: W]),
      .pending (pending[i]),
      .num     (slot_num[i]),
      .den     (slot_den[i])
    );
  end

  assign req_ready = ~pending;
  assign busy      = (state != IDLE) | (|pending);

  // First pending slot after the last winner, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (int'(rr_ptr) + k) % NREQ;
      if (!found && pending[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    cnt_n   = cnt;
    start_n = div_start;
    num_n   = div_num;
    den_n   = div_den;
    rv_n    = 1'b0;
    rid_n   = resp_id;
    res_n   = resp_result;
    err_n   = resp_err;
    clear   = '0;
    case (state)
      IDLE: begin
        if (found) begin
          rr_n = win;
          if (slot_den[win] != '0) begin
            num_n   = slot_num[win];
            den_n   = slot_den[win];
            start_n = 1'b1;
            cnt_n   = '0;
            state_n = ISSUE;
          end else begin
            // Divide by zero never reaches the divider; saturate toward the numerator sign.
            rv_n       = 1'b1;
            err_n      = 1'b1;
            rid_n      = win;
            res_n      = slot_num[win][W-1] ? SAT_NEG : SAT_POS;
            clear[win] = 1'b1;
          end
        end
      end
      ISSUE: begin
        cnt_n = cnt + CW'(1);
        if (div_done) begin
          res_n         = div_result;
          err_n         = 1'b0;
          rv_n          = 1'b1;
          rid_n         = rr_ptr;
          clear[rr_ptr] = 1'b1;
          start_n       = 1'b0;
          state_n       = DRAIN;
        end else if (cnt == CW'(TIMEOUT-1)) begin
          res_n         = '0;
          err_n         = 1'b1;
          rv_n          = 1'b1;
          rid_n         = rr_ptr;
          clear[rr_ptr] = 1'b1;
          start_n       = 1'b0;
          state_n       = DRAIN;
        end
      end
      DRAIN: begin
        // Wait for the divider to drop done before another start can be issued.
        if (!div_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= IW'(NREQ-1);
      cnt         <= '0;
      div_start   <= 1'b0;
      div_num     <= '0;
      div_den     <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_result <= '0;
      resp_err    <= 1'b0;
    end else begin
      state       <= state_n;
      rr_ptr      <= rr_n;
      cnt         <= cnt_n;
      div_start   <= start_n;
      div_num     <= num_n;
      div_den     <= den_n;
      resp_valid  <= rv_n;
      resp_id     <= rid_n;
      resp_result <= res_n;
      resp_err    <= err_n;
    end
  end
endmodule

// File: tb/tb_div_arbiter.sv
// Scoreboard bench for div_arbiter: bursts of simultaneous requests, a timing-aware
// reference of grant order and response cycle, and a 2-cycle divider model with hang/hold knobs.
module tb_div_arbiter;
  localparam int NREQ    = 3;
  localparam int W       = 16;
  localparam int TIMEOUT = 64;
  localparam int IW      = $clog2(NREQ);

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*W-1:0]     req_num = '0;
  logic [NREQ*W-1:0]     req_den = '0;
  logic                  resp_valid, resp_err, busy, div_start, div_done;
  logic [IW-1:0]         resp_id;
  logic [W-1:0]          resp_result, div_num, div_den, div_result;

  always #5 clk = ~clk;

  div_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_num(req_num), .req_den(req_den), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_result(resp_result), .resp_err(resp_err), .busy(busy), .div_start(div_start),
    .div_num(div_num), .div_den(div_den), .div_done(div_done), .div_result(div_result)
  );

  typedef struct {
    int          id;
    logic [W-1:0] res;
    logic        err;
    int          t;
  } exp_t;

  exp_t sbq[$];
  int   nvec = 0, nerr = 0, cyc = 0;
  int   starts = 0, exp_starts = 0, last = NREQ - 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Divider model: Q6.10 quotient, done two edges after start rises.
  int         hold_x = 0, hang_req = 0, hang_done = 0, xcnt = 0;
  logic [1:0] dcnt;
  logic       ds_q;

  function automatic logic [W-1:0] qdiv(input logic [W-1:0] n, input logic [W-1:0] d);
    longint q;
    if (d == '0) return '0;
    q = (longint'($signed(n)) * 64'sd1024) / longint'($signed(d));
    return q[W-1:0];
  endfunction

  assign div_result = qdiv(div_num, div_den);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt     <= '0;
      div_done <= 1'b0;
      xcnt     <= 0;
      ds_q     <= 1'b0;
    end else begin
      ds_q <= div_start;
      if (div_start) begin
        xcnt <= hold_x;
        if (hang_done >= hang_req) begin
          if (dcnt == 2'd1) div_done <= 1'b1;
          else dcnt <= dcnt + 2'd1;
        end
      end else begin
        dcnt <= '0;
        if (div_done && xcnt != 0) xcnt <= xcnt - 1;
        else div_done <= 1'b0;
        if (ds_q && hang_done < hang_req) hang_done <= hang_done + 1;
      end
    end
  end

  // Monitor: pops the scoreboard on every response pulse.
  initial begin
    exp_t e;
    logic start_q, prev_rv;
    logic [IW-1:0] prev_id;
    start_q = 1'b0; prev_rv = 1'b0; prev_id = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (div_start && !start_q) begin
          starts++;
          chk("start_while_done", 32'(div_done), 0);
        end
        if (resp_valid) begin
          if (prev_rv) chk("resp_same_id_twice", 32'(resp_id == prev_id), 0);
          if (sbq.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_resp: got id %0d expected none", resp_id);
          end else begin
            e = sbq.pop_front();
            chk("resp_id", 32'(resp_id), 32'(e.id));
            chk("resp_result", 32'(resp_result), 32'(e.res));
            chk("resp_err", 32'(resp_err), 32'(e.err));
            chk("resp_cycle", cyc, e.t);
            chk("ready_back", 32'(req_ready[resp_id]), 1);
          end
        end
        prev_rv = resp_valid;
        prev_id = resp_id;
      end else begin
        prev_rv = 1'b0;
      end
      start_q = div_start;
    end
  end

  // One burst: mask requesters accept on one edge; the reference orders them round-robin
  // after the last winner and predicts each response cycle from the grant edge.
  // mode 0 normal, 1 done held hx extra cycles, 2 first divide hangs into the timeout.
  task automatic burst(input logic [NREQ-1:0] mask, input int mode, input int hx, input bit rnd,
                       input logic [NREQ-1:0][W-1:0] fn, input logic [NREQ-1:0][W-1:0] fd);
    logic [NREQ-1:0][W-1:0] n, d;
    int   a, t, id, base;
    bit   hung;
    exp_t e;
    n = fn; d = fd;
    hold_x = (mode == 1) ? hx : 0;
    if (mode == 2) hang_req = hang_done + 1;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (rnd) begin
        n[i] = W'($urandom);
        d[i] = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      end
      req_num[i*W +: W] = n[i];
      req_den[i*W +: W] = d[i];
    end
    req_valid = mask;
    @(posedge clk); #1;
    a = cyc;
    req_valid = '0;
    chk("ready_low", 32'(req_ready & mask), 0);
    t = a + 1; hung = 0; base = last;
    for (int k = 1; k <= NREQ; k++) begin
      id = (base + k) % NREQ;
      if (mask[id]) begin
        e.id = id;
        if (d[id] == '0) begin
          e.res = n[id][W-1] ? 16'h8001 : 16'h7FFF; e.err = 1'b1; e.t = t;
          t += 1;
        end else begin
          exp_starts++;
          if (mode == 2 && !hung) begin
            hung = 1;
            e.res = '0; e.err = 1'b1; e.t = t + TIMEOUT;
            t += TIMEOUT + 2;
          end else begin
            e.res = qdiv(n[id], d[id]); e.err = 1'b0; e.t = t + 3;
            t += 6 + hold_x;
          end
        end
        sbq.push_back(e);
        last = id;
      end
    end
    for (int c = 0; c < 400; c++) begin
      if (sbq.size() == 0 && !busy) break;
      @(negedge clk);
    end
    chk("responses_outstanding", 32'(sbq.size()), 0);
    chk("busy_after_drain", 32'(busy), 0);
    chk("start_count", starts, exp_starts);
    sbq.delete();
  endtask

  initial begin
    logic [NREQ-1:0][W-1:0] fn, fd;
    #500000;
    nvec++; nerr++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    logic [NREQ-1:0][W-1:0] fn, fd;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_resp_result", 32'(resp_result), 0);
    chk("rst_div_start", 32'(div_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 32'((1 << NREQ) - 1));
    reset = 1'b0;

    // All three at once right after reset: 0,1,2 spaced 6 cycles.
    fn = {16'h0300, 16'h0200, 16'h0100};
    fd = {16'h0400, 16'h0400, 16'h0400};
    burst(3'b111, 0, 0, 0, fn, fd);

    // Single request from requester 1.
    fn = '0; fd = '0;
    fn[1] = 16'h4000; fd[1] = 16'h1000;
    burst(3'b010, 0, 0, 0, fn, fd);

    // Divide by zero, both signs.
    fn = '0; fd = '0;
    fn[2] = 16'h0123;
    burst(3'b100, 0, 0, 0, fn, fd);
    fn[2] = 16'hF000;
    burst(3'b100, 0, 0, 0, fn, fd);

    // First divide times out, next pending one completes normally.
    fn = {16'h0000, 16'h1234, 16'h0800};
    fd = {16'h0000, 16'h0200, 16'h0100};
    burst(3'b011, 2, 0, 0, fn, fd);

    // Divider holds done three cycles past start dropping.
    fn = {16'h7000, 16'h0000, 16'hC000};
    fd = {16'h0300, 16'h0000, 16'h0500};
    burst(3'b101, 1, 3, 0, fn, fd);

    // Asynchronous reset while a divide is in flight.
    @(negedge clk);
    req_num = {16'h0111, 16'h0222, 16'h0333};
    req_den = {16'h0101, 16'h0202, 16'h0303};
    req_valid = 3'b110;
    @(posedge clk); #1;
    req_valid = '0;
    for (int c = 0; c < 20 && !div_start; c++) @(negedge clk);
    chk("start_before_reset", 32'(div_start), 1);
    @(negedge clk); #2;
    reset = 1'b1; #1;
    chk("arst_div_start", 32'(div_start), 0);
    chk("arst_resp_valid", 32'(resp_valid), 0);
    chk("arst_ready", 32'(req_ready), 32'((1 << NREQ) - 1));
    chk("arst_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    last = NREQ - 1; starts = 0; exp_starts = 0;
    repeat (3) @(negedge clk);
    fn = {16'h0030, 16'h0020, 16'h0010};
    fd = {16'h0003, 16'h0002, 16'h0001};
    burst(3'b111, 0, 0, 0, fn, fd);

    // Randomized bursts.
    for (int r = 0; r < 24; r++)
      burst(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, 1),
            $urandom_range(0, 3), 1, fn, fd);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
